// File: rtl/exec_seq_pkg.sv
// Shared opcode/state enumerations and instruction-field positions for exec_sequencer.
package exec_seq_pkg;

    localparam logic [2:0] FLAG_ADDR_DEFAULT = 3'b111;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int DST_MSB  = 9;
    localparam int DST_LSB  = 8;
    localparam int SRCA_MSB = 5;
    localparam int SRCA_LSB = 4;
    localparam int SRCB_MSB = 1;
    localparam int SRCB_LSB = 0;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    localparam int FLAG_CY_BIT = 7;
    localparam int FLAG_Z_BIT  = 6;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
        OP_XOR  = 4'h4, OP_INV = 4'h5, OP_SHL = 4'h6, OP_MOV = 4'h7,
        OP_LOAD = 4'h8, OP_JZ  = 4'h9, OP_INC = 4'hA, OP_DEC = 4'hB,
        OP_HLT  = 4'hC, OP_JC  = 4'hD, OP_JNZ = 4'hE, OP_JMP = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_RDA, S_RDB, S_EXEC, S_WB, S_WFLAG, S_HALT
    } state_e;

    // Instruction class as seen by the sequencing FSM.
    typedef enum logic [2:0] {
        K_ALU, K_MOV, K_LOAD, K_JMP, K_BRANCH, K_HLT
    } kind_e;

endpackage

// File: rtl/exec_seq_decode.sv
// Combinational opcode-to-control decode for exec_sequencer: instruction class,
// operand read addresses and ALU opcode.
module exec_seq_decode
    import exec_seq_pkg::*;
#(
    parameter logic [2:0] FLAG_ADDR = FLAG_ADDR_DEFAULT
) (
    input  logic [15:0] ir,
    output kind_e       kind,
    output logic [2:0]  alu_op,
    output logic [2:0]  rda_addr,
    output logic [2:0]  rdb_addr,
    output logic        need_rdb,
    output logic        imm_b,
    output logic        br_flag,
    output logic        br_cy,
    output logic [1:0]  dst,
    output logic [7:0]  imm
);

    opcode_e    op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       unused_bits;

    assign op          = opcode_e'(ir[OP_MSB:OP_LSB]);
    assign dst         = ir[DST_MSB:DST_LSB];
    assign src_a       = ir[SRCA_MSB:SRCA_LSB];
    assign src_b       = ir[SRCB_MSB:SRCB_LSB];
    assign imm         = ir[IMM_MSB:IMM_LSB];
    assign unused_bits = ^{ir[11:10], ir[3:2]};

    always_comb begin
        kind     = K_ALU;
        alu_op   = ir[14:12];
        rda_addr = {1'b0, src_a};
        rdb_addr = {1'b0, src_b};
        need_rdb = 1'b1;
        imm_b    = 1'b0;
        br_flag  = 1'b0;
        br_cy    = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: ;
            OP_INV: need_rdb = 1'b0;
            OP_SHL: begin
                rda_addr = {1'b0, dst};
                rdb_addr = {1'b0, src_a};
            end
            OP_INC, OP_DEC: begin
                rda_addr = {1'b0, dst};
                need_rdb = 1'b0;
                imm_b    = 1'b1;
                alu_op   = (op == OP_INC) ? 3'b000 : 3'b001;
            end
            OP_MOV: begin
                kind     = K_MOV;
                need_rdb = 1'b0;
            end
            OP_LOAD: kind = K_LOAD;
            OP_JZ, OP_JC: begin
                kind     = K_BRANCH;
                br_flag  = 1'b1;
                br_cy    = (op == OP_JC);
                rda_addr = FLAG_ADDR;
            end
            OP_JNZ: begin
                kind     = K_BRANCH;
                rda_addr = {1'b0, dst};
            end
            OP_JMP:  kind = K_JMP;
            OP_HLT:  kind = K_HLT;
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer driving external inst_reg, register file and ALU.
// Define SEQ_FLAG_WB_EN to keep the flag byte in the register file (adds the WFLAG state).
//
// state    | meaning
// FETCH    | ir_en high, instruction latched into IR
// DECODE   | classify; JMP/HLT resolve here (and JZ/JC when flags are internal)
// RDA      | read first operand / branch condition register
// RDB      | read second operand
// EXEC     | ALU evaluates, flags captured
// WB       | write result to dst
// WFLAG    | write {cy, zero, 6'b0} to FLAG_ADDR
// HALT     | halted, frozen until reset
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic [2:0] FLAG_ADDR = FLAG_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  pc,
    output logic        ir_en,
    input  logic [15:0] ir_data,
    output logic [2:0]  reg_addr,
    output logic        reg_rd,
    output logic        reg_wr,
    output logic [7:0]  reg_din,
    input  logic [7:0]  reg_dout,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_out,
    input  logic        cy,
    input  logic        zero,
    output logic        halted
);

    state_e      state, state_nxt;
    logic [7:0]  pc_nxt, pc_inc;
    logic [15:0] ir;
    logic [1:0]  flags;
    kind_e       kind;
    logic [2:0]  dec_alu_op, rda_addr, rdb_addr;
    logic        need_rdb, imm_b, br_flag, br_cy, rd_taken;
    logic [1:0]  dst;
    logic [7:0]  imm;

    exec_seq_decode #(.FLAG_ADDR(FLAG_ADDR)) u_decode (
        .ir       (ir),
        .kind     (kind),
        .alu_op   (dec_alu_op),
        .rda_addr (rda_addr),
        .rdb_addr (rdb_addr),
        .need_rdb (need_rdb),
        .imm_b    (imm_b),
        .br_flag  (br_flag),
        .br_cy    (br_cy),
        .dst      (dst),
        .imm      (imm)
    );

    assign pc_inc   = pc + 8'd1;
    assign rd_taken = br_flag ? (br_cy ? reg_dout[FLAG_CY_BIT] : reg_dout[FLAG_Z_BIT])
                              : (reg_dout != 8'h00);
`ifndef SEQ_FLAG_WB_EN
    logic flag_taken;
    assign flag_taken = br_cy ? flags[1] : flags[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (kind)
                    K_HLT:  state_nxt = S_HALT;
                    K_LOAD: state_nxt = S_WB;
                    K_JMP: begin
                        state_nxt = S_FETCH;
                        pc_nxt    = imm;
                    end
`ifndef SEQ_FLAG_WB_EN
                    K_BRANCH: begin
                        if (br_flag) begin
                            state_nxt = S_FETCH;
                            pc_nxt    = flag_taken ? imm : pc_inc;
                        end else begin
                            state_nxt = S_RDA;
                        end
                    end
`endif
                    default: state_nxt = S_RDA;
                endcase
            end
            S_RDA: begin
                case (kind)
                    K_BRANCH: begin
                        state_nxt = S_FETCH;
                        pc_nxt    = rd_taken ? imm : pc_inc;
                    end
                    K_MOV:   state_nxt = S_WB;
                    default: state_nxt = need_rdb ? S_RDB : S_EXEC;
                endcase
            end
            S_RDB:  state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_WB;
            S_WB: begin
`ifdef SEQ_FLAG_WB_EN
                if (kind == K_ALU) begin
                    state_nxt = S_WFLAG;
                end else begin
                    state_nxt = S_FETCH;
                    pc_nxt    = pc_inc;
                end
`else
                state_nxt = S_FETCH;
                pc_nxt    = pc_inc;
`endif
            end
            S_WFLAG: begin
                state_nxt = S_FETCH;
                pc_nxt    = pc_inc;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // alu_op is only reloaded by the next ALU instruction, so it stays put through WB/WFLAG.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            ir     <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            flags  <= '0;
        end else begin
            pc <= pc_nxt;
            case (state)
                S_FETCH: ir <= ir_data;
                S_DECODE: begin
                    if (kind == K_ALU) begin
                        alu_op <= dec_alu_op;
                        if (imm_b) alu_b <= 8'h01;
                    end
                end
                S_RDA:  alu_a <= reg_dout;
                S_RDB:  alu_b <= reg_dout;
                S_EXEC: flags <= {cy, zero};
                default: ;
            endcase
        end
    end

    always_comb begin
        ir_en    = 1'b0;
        reg_rd   = 1'b0;
        reg_wr   = 1'b0;
        reg_addr = '0;
        reg_din  = '0;
        halted   = 1'b0;
        case (state)
            // Reset parks the FSM in FETCH; keep the fetch strobe quiet until release.
            S_FETCH: ir_en = rst_n;
            S_RDA: begin
                reg_rd   = 1'b1;
                reg_addr = rda_addr;
            end
            S_RDB: begin
                reg_rd   = 1'b1;
                reg_addr = rdb_addr;
            end
            S_WB: begin
                reg_wr   = 1'b1;
                reg_addr = {1'b0, dst};
                case (kind)
                    K_LOAD:  reg_din = imm;
                    K_MOV:   reg_din = alu_a;
                    default: reg_din = alu_out;
                endcase
            end
            S_WFLAG: begin
                reg_wr   = 1'b1;
                reg_addr = FLAG_ADDR;
                reg_din  = {flags, 6'b0};
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: ISA-level reference model, directed and random programs.
module tb_exec_sequencer;

`ifdef SEQ_FLAG_WB_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif
    localparam logic [7:0] RPC = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pc;
    logic        ir_en;
    logic [15:0] ir_data;
    logic [2:0]  reg_addr;
    logic        reg_rd, reg_wr;
    logic [7:0]  reg_din, reg_dout;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic        cy, zero, halted;

    logic [15:0] imem [256];
    logic [7:0]  rf [8];
    logic        pre_en = 1'b0;
    logic [2:0]  pre_addr = 3'd0;
    logic [7:0]  pre_data = 8'd0;

    logic [7:0]  mregs [8];
    logic [1:0]  mflags;
    logic [7:0]  mpc;
    logic [7:0]  init_regs [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .ir_en(ir_en), .ir_data(ir_data),
        .reg_addr(reg_addr), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_din(reg_din),
        .reg_dout(reg_dout), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .cy(cy), .zero(zero), .halted(halted)
    );

    function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] r;
        case (op)
            3'd0:    r = {1'b0, x} + {1'b0, y};
            3'd1:    r = {1'b0, x} - {1'b0, y};
            3'd2:    r = {1'b0, x & y};
            3'd3:    r = {1'b0, x | y};
            3'd4:    r = {1'b0, x ^ y};
            3'd5:    r = {1'b0, ~x};
            3'd6:    r = {1'b0, x} << y[2:0];
            default: r = 9'd0;
        endcase
        return r;
    endfunction

    assign {cy, alu_out} = alu_fn(alu_op, alu_a, alu_b);
    assign zero          = (alu_out == 8'h00);
    assign ir_data       = imem[pc];
    assign reg_dout      = rf[reg_addr];

    always @(posedge clk) begin
        if (pre_en)      rf[pre_addr] <= pre_data;
        else if (reg_wr) rf[reg_addr] <= reg_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hC000;
    endtask

    task automatic check_reset_outputs();
        check("rst_pc", pc, RPC);
        check("rst_ir_en", ir_en, 0);
        check("rst_reg_rd", reg_rd, 0);
        check("rst_reg_wr", reg_wr, 0);
        check("rst_halted", halted, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_din", reg_din, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
    endtask

    task automatic start_prog();
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs();
        for (int i = 0; i < 4; i++) begin
            preload(3'(i), init_regs[i]);
            mregs[i] = init_regs[i];
        end
        preload(3'd7, 8'h00);
        mregs[7] = 8'h00;
        mflags   = 2'b00;
        mpc      = RPC;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ir_en", ir_en, 1);
        check("rel_pc", pc, mpc);
    endtask

    task automatic model_alu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y, input int d);
        logic [8:0] r;
        r        = alu_fn(op, x, y);
        mregs[d] = r[7:0];
        mflags   = {r[8], r[7:0] == 8'h00};
        if (M == 1) mregs[7] = {mflags, 6'b0};
    endtask

    // Executes the instruction at mpc in the model, then follows the DUT until its next fetch or halt.
    task automatic run_instr();
        logic [15:0] ins;
        logic [7:0]  imm, nxt;
        int d, a, b, exp_cyc, exp_wr, n, wr_cnt;
        logic exp_halt;
        ins = imem[mpc];
        d = int'(ins[9:8]); a = int'(ins[5:4]); b = int'(ins[1:0]);
        imm = ins[7:0];
        nxt = mpc + 8'd1;
        exp_halt = 1'b0;
        exp_wr = 0;
        exp_cyc = 0;
        case (ins[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
                model_alu(ins[14:12], mregs[a], mregs[b], d); exp_cyc = 6 + M; exp_wr = 1 + M;
            end
            4'h5: begin model_alu(3'd5, mregs[a], 8'h00, d);    exp_cyc = 5 + M; exp_wr = 1 + M; end
            4'h6: begin model_alu(3'd6, mregs[d], mregs[a], d); exp_cyc = 6 + M; exp_wr = 1 + M; end
            4'hA: begin model_alu(3'd0, mregs[d], 8'h01, d);    exp_cyc = 5 + M; exp_wr = 1 + M; end
            4'hB: begin model_alu(3'd1, mregs[d], 8'h01, d);    exp_cyc = 5 + M; exp_wr = 1 + M; end
            4'h7: begin mregs[d] = mregs[a]; exp_cyc = 4; exp_wr = 1; end
            4'h8: begin mregs[d] = imm;      exp_cyc = 3; exp_wr = 1; end
            4'h9: begin if (mflags[0]) nxt = imm; exp_cyc = 2 + M; end
            4'hD: begin if (mflags[1]) nxt = imm; exp_cyc = 2 + M; end
            4'hE: begin if (mregs[d] != 8'h00) nxt = imm; exp_cyc = 3; end
            4'hF: begin nxt = imm; exp_cyc = 2; end
            default: begin exp_halt = 1'b1; nxt = mpc; exp_cyc = 2; end
        endcase
        mpc = nxt;
        n = 0;
        wr_cnt = 0;
        do begin
            @(negedge clk);
            n++;
            check("rd_wr_exclusive", {31'd0, reg_rd & reg_wr}, 0);
            if (reg_wr) wr_cnt++;
        end while (!ir_en && !halted && n < 30);
        check($sformatf("cycles_op%0h", ins[15:12]), n, exp_cyc);
        check($sformatf("wr_pulses_op%0h", ins[15:12]), wr_cnt, exp_wr);
        check("halted", halted, exp_halt);
        check("pc_after", pc, mpc);
        for (int i = 0; i < 4; i++) check($sformatf("r%0d", i), rf[i], mregs[i]);
        if (M == 1) check("flag_byte", rf[7], mregs[7]);
    endtask

    initial begin
        logic [31:0] w;
        int k;

        // ADD 5+3, then HLT holds for 20 cycles
        clear_imem();
        imem[0] = 16'h8005; imem[1] = 16'h8103; imem[2] = 16'h0201; imem[3] = 16'hC000;
        for (int i = 0; i < 4; i++) init_regs[i] = 8'h00;
        start_prog();
        for (int i = 0; i < 4; i++) run_instr();
        check("add_r2", rf[2], 8'h08);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_hold", {halted, ir_en, reg_rd, reg_wr}, 4'b1000);
            check("halt_pc", pc, 8'h03);
        end

        // DEC to zero, JZ taken
        clear_imem();
        imem[0] = 16'h8001; imem[1] = 16'hB000; imem[2] = 16'h9020;
        start_prog();
        for (int i = 0; i < 3; i++) run_instr();
        check("jz_target", pc, 8'h20);

        // INC wraps with carry, JC taken
        clear_imem();
        imem[0] = 16'h80FF; imem[1] = 16'hA000; imem[2] = 16'hD010;
        start_prog();
        for (int i = 0; i < 3; i++) run_instr();
        check("inc_wrap_r0", rf[0], 8'h00);
        check("jc_target", pc, 8'h10);

        // PC wrap from 8'hFF
        clear_imem();
        imem[0] = 16'hF0FF; imem[255] = 16'h8177;
        start_prog();
        run_instr();
        run_instr();
        check("pc_wrap", pc, 8'h00);

        // Reset asserted during WB of ADD
        clear_imem();
        imem[0] = 16'h8005; imem[1] = 16'h8103; imem[2] = 16'h0201;
        init_regs[2] = 8'hAA;
        start_prog();
        run_instr();
        run_instr();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!reg_wr && k < 20);
        check("wb_reached", reg_wr, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) begin
            @(negedge clk);
            check("no_wr_in_reset", reg_wr, 0);
        end
        check("aborted_r2", rf[2], 8'hAA);
        rst_n = 1'b1;
        #1;
        check("post_rst_fetch", ir_en, 1);
        check("post_rst_pc", pc, RPC);

        // Random programs over the whole instruction space except HLT
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 256; i++) begin
                do w = $urandom; while (w[15:12] == 4'hC);
                imem[i] = w[15:0];
            end
            w = $urandom;
            imem[0] = w[15:0] & 16'h0333;
            for (int i = 0; i < 4; i++) begin
                w = $urandom;
                init_regs[i] = w[7:0];
            end
            start_prog();
            for (int s = 0; s < 50; s++) run_instr();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
